// File: rtl/tlb_mmu.sv
// Joint TLB array and dual-port (inst/data) address translation with CP0 tlbp/tlbr/tlbwi support.
// Optional TLB_TLBWR_EN adds the Random register, the wired input and the tlbwr write path.
module tlb_mmu #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            rst,
`ifdef TLB_TLBWR_EN
   input  logic [3:0]      tlb_typeM,
   input  logic [IDXW-1:0] wired,
   output logic [31:0]     random_out,
`else
   input  logic [2:0]      tlb_typeM,
`endif
   input  logic            stallM,
   input  logic            flush_exception,
   input  logic [31:0]     entry_hi_W,
   input  logic [31:0]     entry_lo0_W,
   input  logic [31:0]     entry_lo1_W,
   input  logic [31:0]     index_W,
   output logic [31:0]     index_in,
   output logic [31:0]     entry_hi_in,
   output logic [31:0]     entry_lo0_in,
   output logic [31:0]     entry_lo1_in,
   output logic [31:0]     page_mask_in,
   input  logic            inst_en,
   input  logic            data_en,
   input  logic            inst_stall,
   input  logic            data_stall,
   input  logic [31:0]     inst_vaddr,
   input  logic [31:0]     data_vaddr,
   input  logic            data_store,
   output logic [31:0]     inst_paddr,
   output logic [31:0]     data_paddr,
   output logic            inst_uncached,
   output logic            data_uncached,
   output logic            inst_refill,
   output logic            data_refill,
   output logic            inst_invalid,
   output logic            data_invalid,
   output logic            data_modify
);

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } half_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      half_t       lo0;
      half_t       lo1;
   } entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        uncached;
      logic        refill;
      logic        invalid;
      logic        modify;
   } res_t;

   entry_t          tlb [TLBNUM];
   entry_t          wr_entry;
   entry_t          rd_entry;
   logic            wr_en;
   logic [IDXW-1:0] wr_idx;
   logic [TLBNUM-1:0] probe_hit, inst_hit, data_hit;
   res_t            inst_res, data_res;
   res_t            inst_q, data_q;

   function automatic logic entry_match(input entry_t e, input logic [18:0] vpn2,
                                        input logic [7:0] asid);
      return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
   endfunction

   // Lowest set bit wins when several entries match.
   function automatic logic [IDXW-1:0] first_idx(input logic [TLBNUM-1:0] v);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
         if (v[i]) idx = IDXW'(i);
      end
      return idx;
   endfunction

   function automatic res_t translate(input logic [31:0] va, input logic hit,
                                      input entry_t e, input logic store);
      res_t  r;
      half_t h;
      r = '0;
      h = va[12] ? e.lo1 : e.lo0;
      if (va[31:30] == 2'b10) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = va[29];
      end else if (!hit) begin
         r.refill = 1'b1;
      end else if (!h.v) begin
         r.invalid = 1'b1;
      end else begin
         r.paddr    = {h.pfn, va[11:0]};
         r.uncached = (h.c == 3'd2);
         r.modify   = store && !h.d;
      end
      return r;
   endfunction

   for (genvar i = 0; i < int'(TLBNUM); i++) begin : g_match
      assign probe_hit[i] = entry_match(tlb[i], entry_hi_W[31:13], entry_hi_W[7:0]);
      assign inst_hit[i]  = entry_match(tlb[i], inst_vaddr[31:13], entry_hi_W[7:0]);
      assign data_hit[i]  = entry_match(tlb[i], data_vaddr[31:13], entry_hi_W[7:0]);
   end

`ifdef TLB_TLBWR_EN
   logic [IDXW-1:0] random_q;

   // Random counts down from TLBNUM-1 to wired, then wraps.
   always_ff @(posedge clk) begin
      if (rst)
         random_q <= IDXW'(TLBNUM - 1);
      else if ((wired >= IDXW'(TLBNUM - 1)) || (random_q <= wired))
         random_q <= IDXW'(TLBNUM - 1);
      else
         random_q <= random_q - IDXW'(1);
   end

   assign random_out = 32'(random_q);
   assign wr_en  = (tlb_typeM[2] || tlb_typeM[3]) && !stallM && !flush_exception;
   assign wr_idx = tlb_typeM[2] ? index_W[IDXW-1:0] : random_q;
`else
   assign wr_en  = tlb_typeM[2] && !stallM && !flush_exception;
   assign wr_idx = index_W[IDXW-1:0];
`endif

   assign wr_entry = '{vpn2: entry_hi_W[31:13],
                       asid: entry_hi_W[7:0],
                       g:    entry_lo0_W[0] & entry_lo1_W[0],
                       lo0:  entry_lo0_W[25:1],
                       lo1:  entry_lo1_W[25:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(TLBNUM); i++) tlb[i] <= '0;
      end else if (wr_en) begin
         tlb[wr_idx] <= wr_entry;
      end
   end

   // CP0 probe/read results are combinational from the current array contents.
   assign rd_entry     = tlb[index_W[IDXW-1:0]];
   assign index_in     = (|probe_hit) ? 32'(first_idx(probe_hit)) : 32'h8000_0000;
   assign entry_hi_in  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
   assign entry_lo0_in = {6'b0, rd_entry.lo0, rd_entry.g};
   assign entry_lo1_in = {6'b0, rd_entry.lo1, rd_entry.g};
   assign page_mask_in = 32'h0;

   always_comb begin
      inst_res = translate(inst_vaddr, |inst_hit, tlb[first_idx(inst_hit)], 1'b0);
      data_res = translate(data_vaddr, |data_hit, tlb[first_idx(data_hit)], data_store);
   end

   always_ff @(posedge clk) begin
      if (rst)              inst_q <= '0;
      else if (!inst_stall) inst_q <= inst_en ? inst_res : '0;
   end

   always_ff @(posedge clk) begin
      if (rst)              data_q <= '0;
      else if (!data_stall) data_q <= data_en ? data_res : '0;
   end

   assign inst_paddr    = inst_q.paddr;
   assign inst_uncached = inst_q.uncached;
   assign inst_refill   = inst_q.refill;
   assign inst_invalid  = inst_q.invalid;
   assign data_paddr    = data_q.paddr;
   assign data_uncached = data_q.uncached;
   assign data_refill   = data_q.refill;
   assign data_invalid  = data_q.invalid;
   assign data_modify   = data_q.modify;

   logic unused_ok;
   assign unused_ok = ^{index_W[31:IDXW], entry_hi_W[12:8], entry_lo0_W[31:26],
                        entry_lo1_W[31:26], tlb_typeM[1:0], inst_q.modify};

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: table of lookup vectors plus hand sequences for
// write gating, probe/read, stall hold and reset; Random sequence when TLB_TLBWR_EN is set.
module tb_tlb_mmu;

`ifdef TLB_TLBWR_EN
   localparam int unsigned TW = 4;
   logic [3:0]  wired;
   logic [31:0] random_out;
`else
   localparam int unsigned TW = 3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] tlb_typeM;
   logic          stallM, flush_exception;
   logic [31:0]   entry_hi_W, entry_lo0_W, entry_lo1_W, index_W;
   logic [31:0]   index_in, entry_hi_in, entry_lo0_in, entry_lo1_in, page_mask_in;
   logic          inst_en, data_en, inst_stall, data_stall, data_store;
   logic [31:0]   inst_vaddr, data_vaddr, inst_paddr, data_paddr;
   logic          inst_uncached, data_uncached, inst_refill, data_refill;
   logic          inst_invalid, data_invalid, data_modify;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   tlb_mmu dut (
      .clk(clk), .rst(rst), .tlb_typeM(tlb_typeM),
`ifdef TLB_TLBWR_EN
      .wired(wired), .random_out(random_out),
`endif
      .stallM(stallM), .flush_exception(flush_exception),
      .entry_hi_W(entry_hi_W), .entry_lo0_W(entry_lo0_W), .entry_lo1_W(entry_lo1_W),
      .index_W(index_W), .index_in(index_in), .entry_hi_in(entry_hi_in),
      .entry_lo0_in(entry_lo0_in), .entry_lo1_in(entry_lo1_in), .page_mask_in(page_mask_in),
      .inst_en(inst_en), .data_en(data_en), .inst_stall(inst_stall), .data_stall(data_stall),
      .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr), .data_store(data_store),
      .inst_paddr(inst_paddr), .data_paddr(data_paddr),
      .inst_uncached(inst_uncached), .data_uncached(data_uncached),
      .inst_refill(inst_refill), .data_refill(data_refill),
      .inst_invalid(inst_invalid), .data_invalid(data_invalid), .data_modify(data_modify)
   );

   typedef struct {
      logic [31:0] va;
      logic        store;
      logic [7:0]  asid;
      logic        chk_pa;
      logic [31:0] pa;
      logic        unc;
      logic        refill;
      logic        inv;
      logic        modify;
   } vec_t;

   vec_t vt [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tlbwi(input logic [31:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1);
      tlb_typeM   = TW'(4);
      index_W     = idx;
      entry_hi_W  = hi;
      entry_lo0_W = lo0;
      entry_lo1_W = lo1;
      step();
      tlb_typeM   = '0;
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         entry_hi_W = {24'h0, vt[i].asid};
         inst_en    = 1'b1;
         data_en    = 1'b1;
         inst_vaddr = vt[i].va;
         data_vaddr = vt[i].va;
         data_store = vt[i].store;
         step();
         if (vt[i].chk_pa) begin
            chk($sformatf("v%0d data_paddr", i), data_paddr, vt[i].pa);
            chk($sformatf("v%0d data_unc", i), 32'(data_uncached), 32'(vt[i].unc));
            chk($sformatf("v%0d inst_paddr", i), inst_paddr, vt[i].pa);
            chk($sformatf("v%0d inst_unc", i), 32'(inst_uncached), 32'(vt[i].unc));
         end
         chk($sformatf("v%0d data_flags", i), 32'({data_refill, data_invalid, data_modify}),
             32'({vt[i].refill, vt[i].inv, vt[i].modify}));
         chk($sformatf("v%0d inst_flags", i), 32'({inst_refill, inst_invalid}),
             32'({vt[i].refill, vt[i].inv}));
      end
   endtask

   initial begin
      // va, store, asid, chk_pa, pa, unc, refill, inv, modify
      vt[0]  = '{32'h0040_0000, 1'b0, 8'h05, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{32'hA000_1234, 1'b0, 8'h05, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{32'h8012_3456, 1'b0, 8'h05, 1'b1, 32'h0012_3456, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{32'hC040_0000, 1'b0, 8'h05, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[4]  = '{32'h0040_0ABC, 1'b0, 8'h05, 1'b1, 32'h0004_0ABC, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{32'h0040_1000, 1'b0, 8'h05, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{32'h0040_0000, 1'b1, 8'h05, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[7]  = '{32'h0040_0FFF, 1'b0, 8'h05, 1'b1, 32'h0004_0FFF, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{32'h0040_0ABC, 1'b0, 8'h06, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[9]  = '{32'h0040_0ABC, 1'b0, 8'h06, 1'b1, 32'h0004_0ABC, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[10] = '{32'h0040_1ABC, 1'b0, 8'h06, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[11] = '{32'h0040_0000, 1'b1, 8'h06, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; tlb_typeM = '0; stallM = 1'b0; flush_exception = 1'b0;
      entry_hi_W = '0; entry_lo0_W = '0; entry_lo1_W = '0; index_W = '0;
      inst_en = 1'b0; data_en = 1'b0; inst_stall = 1'b0; data_stall = 1'b0;
      inst_vaddr = '0; data_vaddr = '0; data_store = 1'b0;
`ifdef TLB_TLBWR_EN
      wired = 4'd2;
`endif
      step();
      step();
      rst = 1'b0;
      chk("rst data_paddr", data_paddr, 32'h0);
      chk("rst inst_paddr", inst_paddr, 32'h0);
      chk("rst flags", 32'({inst_uncached, inst_refill, inst_invalid, data_uncached,
                            data_refill, data_invalid, data_modify}), 32'h0);

`ifdef TLB_TLBWR_EN
      chk("random start", random_out, 32'd15);
      for (int k = 14; k >= 2; k--) begin
         step();
         chk($sformatf("random %0d", k), random_out, 32'(k));
      end
      step();
      chk("random wrap", random_out, 32'd15);
`endif

      // Unmapped segments and misses on the empty array
      run_rows(0, 3);

      // Entry 3: PFN 0x40, even half C=2 D=0 V=1, odd half V=0, not global
      tlbwi(32'd3, 32'h0040_0005, 32'h0000_1012, 32'h0000_2018);
      run_rows(4, 8);

      // Same entry made global
      tlbwi(32'd3, 32'h0040_0005, 32'h0000_1013, 32'h0000_2019);
      run_rows(9, 11);

      // Probe: duplicate at 7 must not beat 3; G is the AND of both halves
      tlbwi(32'd7, 32'h0040_0005, 32'h0000_1012, 32'h0000_2019);
      tlbwi(32'd9, 32'h0080_0007, 32'h0000_1012, 32'h0000_2018);
      entry_hi_W = 32'h0040_0005; #1;
      chk("tlbp lowest", index_in, 32'h0000_0003);
      entry_hi_W = 32'h0080_0007; #1;
      chk("tlbp idx9", index_in, 32'h0000_0009);
      entry_hi_W = 32'h7FFF_E005; #1;
      chk("tlbp miss", index_in, 32'h8000_0000);
      index_W = 32'd3; #1;
      chk("tlbr3 hi", entry_hi_in, 32'h0040_0005);
      chk("tlbr3 lo0", entry_lo0_in, 32'h0000_1013);
      chk("tlbr3 lo1", entry_lo1_in, 32'h0000_2019);
      chk("tlbr3 pmask", page_mask_in, 32'h0);
      index_W = 32'd7; #1;
      chk("tlbr7 lo0", entry_lo0_in, 32'h0000_1012);
      chk("tlbr7 lo1", entry_lo1_in, 32'h0000_2018);

      // Write gating by stallM and flush_exception
      stallM = 1'b1;
      tlbwi(32'd3, 32'h1234_6005, 32'h0, 32'h0);
      stallM = 1'b0;
      index_W = 32'd3; #1;
      chk("stallM blocks write", entry_hi_in, 32'h0040_0005);
      flush_exception = 1'b1;
      tlbwi(32'd3, 32'h1234_6005, 32'h0, 32'h0);
      flush_exception = 1'b0;
      index_W = 32'd3; #1;
      chk("flush blocks write", entry_lo0_in, 32'h0000_1013);

      // Multi-hot tlb_typeM still writes
      tlb_typeM = '1; index_W = 32'd5;
      entry_hi_W = 32'h0060_0005; entry_lo0_W = 32'h0000_1012; entry_lo1_W = 32'h0000_2018;
      step();
      tlb_typeM = '0; #1;
      chk("multihot write", entry_hi_in, 32'h0060_0005);

      // Lookup in the write cycle sees the old entry, next cycle the new one
      data_en = 1'b1; data_store = 1'b0; data_vaddr = 32'h0040_0ABC;
      tlbwi(32'd3, 32'h0040_0005, 32'h0000_155F, 32'h0000_2019);
      chk("same-cycle old paddr", data_paddr, 32'h0004_0ABC);
      chk("same-cycle old unc", 32'(data_uncached), 32'd1);
      step();
      chk("next-cycle new paddr", data_paddr, 32'h0005_5ABC);
      chk("next-cycle new unc", 32'(data_uncached), 32'd0);

      // inst_stall holds the result while the address moves
      inst_en = 1'b1; inst_stall = 1'b0; inst_vaddr = 32'hA000_1000;
      step();
      chk("inst pre-stall", inst_paddr, 32'h0000_1000);
      inst_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         inst_vaddr = 32'h8000_2000 + 32'(k * 32'h100);
         step();
         chk($sformatf("inst hold %0d", k), inst_paddr, 32'h0000_1000);
         chk($sformatf("inst hold unc %0d", k), 32'(inst_uncached), 32'd1);
      end
      inst_stall = 1'b0; inst_en = 1'b0; data_en = 1'b0;
      step();
      chk("inst idle zero", inst_paddr, 32'h0);
      chk("data idle zero", data_paddr, 32'h0);
      chk("idle flags zero", 32'({inst_uncached, data_uncached}), 32'h0);

`ifdef TLB_TLBWR_EN
      begin
         logic [31:0] r;
         r = random_out;
         tlb_typeM = TW'(8);
         entry_hi_W = 32'h00A0_0005; entry_lo0_W = 32'h0000_1012; entry_lo1_W = 32'h0000_2019;
         step();
         tlb_typeM = '0;
         index_W = r; #1;
         chk("tlbwr at random", entry_hi_in, 32'h00A0_0005);
      end
`endif

      // Reset wins over a same-cycle write and clears the array
      rst = 1'b1;
      tlbwi(32'd3, 32'h0040_0005, 32'h0000_1013, 32'h0000_2019);
      rst = 1'b0;
      index_W = 32'd3; #1;
      chk("reset beats write hi", entry_hi_in, 32'h0);
      chk("reset beats write lo0", entry_lo0_in, 32'h0);
      entry_hi_W = 32'h0000_0005; data_en = 1'b1; data_vaddr = 32'h0040_0000;
      step();
      chk("post-reset refill", 32'(data_refill), 32'd1);
      chk("post-reset paddr", data_paddr, 32'h0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
